reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter_if.sv | 27 ++
 rtl/reg_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Register-bus port between the two-master arbiter and the regmap.
// Signal names are the arbiter's port names; the master modport is the arbiter side.
interface reg_bus_arbiter_if #(
  parameter int ADDRESS_WIDTH = 9
);
  // Handshake: rreq_o/wreq_o pulse for one cycle with address/data stable from
  // that cycle until the next grant; the regmap answers later with a single-cycle
  // rack_i/wack_i (rdata_i valid alongside rack_i). Acks at any other time are ignored.
  logic                     rreq_o;
  logic [ADDRESS_WIDTH-1:0] raddr_o;
  logic [31:0]              rdata_i;
  logic                     rack_i;
  logic                     wreq_o;
  logic [ADDRESS_WIDTH-1:0] waddr_o;
  logic [31:0]              wdata_o;
  logic                     wack_i;

  modport master (
    output rreq_o, raddr_o, wreq_o, waddr_o, wdata_o,
    input  rdata_i, rack_i, wack_i
  );

  modport slave (
    input  rreq_o, raddr_o, wreq_o, waddr_o, wdata_o,
    output rdata_i, rack_i, wack_i
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register read/write port between two masters,
// with a per-transaction wait timeout that completes the access with an error flag.
module reg_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 9,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     m0_req_i,
  input  logic                     m0_wr_i,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr_i,
  input  logic [31:0]              m0_wdata_i,
  output logic                     m0_ack_o,
  output logic [31:0]              m0_rdata_o,
  output logic                     m0_err_o,
  input  logic                     m1_req_i,
  input  logic                     m1_wr_i,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
  input  logic [31:0]              m1_wdata_i,
  output logic                     m1_ack_o,
  output logic [31:0]              m1_rdata_o,
  output logic                     m1_err_o,
  reg_bus_arbiter_if.master        regbus,
  output logic                     busy_o,
  output logic                     grant_o,
  output logic [15:0]              timeout_cnt_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     grant_q;
  logic                     wr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [15:0]              wait_cnt_q;
  logic [15:0]              tmo_cnt_q;
  logic [31:0]              m0_rdata_q, m1_rdata_q;
  logic                     m0_err_q, m1_err_q;

  logic        req_any, win, hit;
  logic        take, done_ok, tmo;
  logic [31:0] resp_data;

  assign req_any   = m0_req_i | m1_req_i;
  // On a tie the master that was not granted last goes next.
  assign win       = (m0_req_i & m1_req_i) ? ~grant_q : m1_req_i;
  assign hit       = wr_q ? regbus.wack_i : regbus.rack_i;
  assign resp_data = (done_ok & ~wr_q) ? regbus.rdata_i : 32'd0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done_ok = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (hit) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      grant_q    <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      if (take) begin
        grant_q <= win;
        wr_q    <= win ? m1_wr_i    : m0_wr_i;
        addr_q  <= win ? m1_addr_i  : m0_addr_i;
        wdata_q <= win ? m1_wdata_i : m0_wdata_i;
      end
      if (state_q == ISSUE)
        wait_cnt_q <= '0;
      else if (state_q == WAIT && !done_ok && !tmo)
        wait_cnt_q <= wait_cnt_q + 16'd1;
      if (tmo && tmo_cnt_q != 16'hFFFF)
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      // Response registers belong to each master so they hold until its next ack.
      if (done_ok || tmo) begin
        if (grant_q) begin
          m1_rdata_q <= resp_data;
          m1_err_q   <= tmo;
        end else begin
          m0_rdata_q <= resp_data;
          m0_err_q   <= tmo;
        end
      end
    end
  end

  assign regbus.rreq_o  = (state_q == ISSUE) & ~wr_q;
  assign regbus.wreq_o  = (state_q == ISSUE) &  wr_q;
  assign regbus.raddr_o = addr_q;
  assign regbus.waddr_o = addr_q;
  assign regbus.wdata_o = wdata_q;

  assign m0_ack_o      = (state_q == RESP) & ~grant_q;
  assign m1_ack_o      = (state_q == RESP) &  grant_q;
  assign m0_rdata_o    = m0_rdata_q;
  assign m1_rdata_o    = m1_rdata_q;
  assign m0_err_o      = m0_err_q;
  assign m1_err_o      = m1_err_q;
  assign busy_o        = (state_q != IDLE);
  assign grant_o       = grant_q;
  assign timeout_cnt_o = tmo_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios with literal expectations, then
// random masters/regmap traffic checked every cycle against a transaction-level model.
module tb_reg_bus_arbiter;
  localparam int AW  = 9;
  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req_i, m0_wr_i, m1_req_i, m1_wr_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [31:0]   m0_wdata_i, m1_wdata_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0]   m0_rdata_o, m1_rdata_o;
  logic          busy_o, grant_o;
  logic [15:0]   timeout_cnt_o;
  logic [1:0]    state_o;

  reg_bus_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

  reg_bus_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .m0_req_i(m0_req_i), .m0_wr_i(m0_wr_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_wr_i(m1_wr_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .regbus(bus.master),
    .busy_o(busy_o), .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o), .state_o(state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic          m_busy, m_done, m_own, m_wr, m_grant;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata [2];
  logic          m_err [2];
  int            m_tcnt;
  logic [33:0]   exp_q [$];

  logic          c_rst, c_req0, c_req1, c_wr0, c_wr1, c_rack, c_wack;
  logic [AW-1:0] c_addr0, c_addr1;
  logic [31:0]   c_wd0, c_wd1, c_rdata;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_own = 0; m_wr = 0; m_grant = 1; m_age = 0;
    m_addr = '0; m_wdata = '0; m_tcnt = 0;
    for (int i = 0; i < 2; i++) begin m_rdata[i] = '0; m_err[i] = 0; end
    exp_q.delete();
  endtask

  task automatic model_finish(input logic e, input logic [31:0] d);
    m_rdata[m_own] = d;
    m_err[m_own]   = e;
    m_done         = 1;
    exp_q.push_back({m_own, e, d});
  endtask

  // m_age counts cycles since the grant: 0 is the issue cycle, 1..TMO are wait cycles.
  task automatic model_step();
    logic w;
    if (!m_busy) begin
      if (c_req0 || c_req1) begin
        w = (c_req0 && c_req1) ? !m_grant : c_req1;
        m_grant = w; m_own = w;
        m_wr    = w ? c_wr1 : c_wr0;
        m_addr  = w ? c_addr1 : c_addr0;
        m_wdata = w ? c_wd1 : c_wd0;
        m_busy = 1; m_done = 0; m_age = 0;
      end
    end else if (m_done) begin
      m_busy = 0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_wr ? c_wack : c_rack) begin
      model_finish(1'b0, m_wr ? 32'd0 : c_rdata);
    end else if (m_age == TMO) begin
      model_finish(1'b1, 32'd0);
      if (m_tcnt < 65535) m_tcnt++;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_all();
    logic [33:0] e;
    chk("busy",    busy_o, m_busy);
    chk("state_busy", state_o != 2'd0, m_busy);
    chk("grant",   grant_o, m_grant);
    chk("rreq",    bus.rreq_o, m_busy && !m_done && m_age == 0 && !m_wr);
    chk("wreq",    bus.wreq_o, m_busy && !m_done && m_age == 0 && m_wr);
    chk("raddr",   bus.raddr_o, m_addr);
    chk("waddr",   bus.waddr_o, m_addr);
    chk("wdata",   bus.wdata_o, m_wdata);
    chk("ack0",    m0_ack_o, m_busy && m_done && m_own == 1'b0);
    chk("ack1",    m1_ack_o, m_busy && m_done && m_own == 1'b1);
    chk("rdata0",  m0_rdata_o, m_rdata[0]);
    chk("rdata1",  m1_rdata_o, m_rdata[1]);
    chk("err0",    m0_err_o, m_err[0]);
    chk("err1",    m1_err_o, m_err[1]);
    chk("tcnt",    timeout_cnt_o, m_tcnt);
    if (m0_ack_o || m1_ack_o) begin
      chk("resp_q_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("resp_owner", m1_ack_o, e[33]);
        chk("resp_err",   m1_ack_o ? m1_err_o : m0_err_o, e[32]);
        chk("resp_rdata", m1_ack_o ? m1_rdata_o : m0_rdata_o, e[31:0]);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      c_rst = reset_ni; c_req0 = m0_req_i; c_req1 = m1_req_i;
      c_wr0 = m0_wr_i; c_wr1 = m1_wr_i; c_addr0 = m0_addr_i; c_addr1 = m1_addr_i;
      c_wd0 = m0_wdata_i; c_wd1 = m1_wdata_i;
      c_rack = bus.rack_i; c_wack = bus.wack_i; c_rdata = bus.rdata_i;
      #1;
      if (!c_rst) model_reset();
      else        model_step();
      compare_all();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_master(input logic ack, inout logic req, inout logic wr,
                              inout logic [AW-1:0] addr, inout logic [31:0] wdata);
    if (req && ack) begin
      req = ($urandom_range(0, 7) == 0);
    end else if (!req) begin
      req = ($urandom_range(0, 2) == 0);
      wr = 1'($urandom_range(0, 1)); addr = AW'($urandom); wdata = $urandom;
    end else if ($urandom_range(0, 3) == 0) begin
      wr = 1'($urandom_range(0, 1)); addr = AW'($urandom); wdata = $urandom;
    end
  endtask

  task automatic rand_cycle();
    drive_master(m0_ack_o, m0_req_i, m0_wr_i, m0_addr_i, m0_wdata_i);
    drive_master(m1_ack_o, m1_req_i, m1_wr_i, m1_addr_i, m1_wdata_i);
    bus.rack_i  = ($urandom_range(0, 3) == 0);
    bus.wack_i  = ($urandom_range(0, 3) == 0);
    bus.rdata_i = $urandom;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    m0_req_i = 0; m0_wr_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_wr_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
    bus.rack_i = 0; bus.wack_i = 0; bus.rdata_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy",  busy_o, 0);
    chk("rst_grant", grant_o, 1);
    chk("rst_tcnt",  timeout_cnt_o, 0);
    chk("rst_raddr", bus.raddr_o, 0);
    reset_ni = 1;
    step();

    // single read by m0, one-cycle regmap latency
    m0_req_i = 1; m0_wr_i = 0; m0_addr_i = 9'h000;
    step();
    chk("rd_rreq", bus.rreq_o, 1);
    chk("rd_raddr", bus.raddr_o, 32'h0);
    step();
    chk("rd_rreq_pulse", bus.rreq_o, 0);
    chk("rd_early_ack", m0_ack_o, 0);
    bus.rack_i = 1; bus.rdata_i = 32'h00040069;
    step();
    bus.rack_i = 0;
    chk("rd_ack", m0_ack_o, 1);
    chk("rd_other_ack", m1_ack_o, 0);
    chk("rd_rdata", m0_rdata_o, 32'h00040069);
    chk("rd_err", m0_err_o, 0);
    m0_req_i = 0;
    step();
    chk("rd_ack_pulse", m0_ack_o, 0);
    chk("rd_idle", busy_o, 0);

    // write by m1
    m1_req_i = 1; m1_wr_i = 1; m1_addr_i = 9'h005; m1_wdata_i = 32'hA5A5A5A5;
    step();
    chk("wr_wreq", bus.wreq_o, 1);
    chk("wr_rreq", bus.rreq_o, 0);
    chk("wr_waddr", bus.waddr_o, 32'h5);
    chk("wr_wdata", bus.wdata_o, 32'hA5A5A5A5);
    chk("wr_grant", grant_o, 1);
    step();
    chk("wr_wreq_pulse", bus.wreq_o, 0);
    bus.wack_i = 1;
    step();
    bus.wack_i = 0;
    chk("wr_ack", m1_ack_o, 1);
    chk("wr_m0_ack", m0_ack_o, 0);
    chk("wr_err", m1_err_o, 0);
    chk("wr_rdata", m1_rdata_o, 0);
    chk("wr_rdata0_held", m0_rdata_o, 32'h00040069);
    m1_req_i = 0;
    step();

    // timeout with no regmap answer
    m0_req_i = 1; m0_wr_i = 0; m0_addr_i = 9'h010;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("tmo_no_ack", m0_ack_o, 0);
    end
    step();
    chk("tmo_ack", m0_ack_o, 1);
    chk("tmo_err", m0_err_o, 1);
    chk("tmo_rdata", m0_rdata_o, 0);
    chk("tmo_cnt", timeout_cnt_o, 1);
    m0_req_i = 0;
    step();

    // ack landing on the last wait cycle beats the timeout
    m0_req_i = 1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("edge_no_ack", m0_ack_o, 0);
      if (c == 5) begin bus.rack_i = 1; bus.rdata_i = 32'h12345678; end
    end
    step();
    bus.rack_i = 0;
    chk("edge_ack", m0_ack_o, 1);
    chk("edge_err", m0_err_o, 0);
    chk("edge_rdata", m0_rdata_o, 32'h12345678);
    chk("edge_cnt", timeout_cnt_o, 1);
    m0_req_i = 0;
    step();

    // stray rack in idle, wrong-type ack during a read
    bus.rack_i = 1;
    step();
    bus.rack_i = 0;
    chk("stray_busy", busy_o, 0);
    chk("stray_ack", m0_ack_o, 0);
    m0_req_i = 1; m0_wr_i = 0; m0_addr_i = 9'h1FF;
    step();
    step();
    bus.wack_i = 1;
    step();
    bus.wack_i = 0;
    chk("wrongack_no_ack", m0_ack_o, 0);
    chk("wrongack_busy", busy_o, 1);
    bus.rack_i = 1; bus.rdata_i = 32'hDEADBEEF;
    step();
    bus.rack_i = 0;
    chk("wrongack_ack", m0_ack_o, 1);
    chk("wrongack_rdata", m0_rdata_o, 32'hDEADBEEF);
    chk("wrongack_err", m0_err_o, 0);
    m0_req_i = 0;
    step();

    // reset during wait, then a fresh m1 read
    m0_req_i = 1; m0_wr_i = 0; m0_addr_i = 9'h0AA;
    step();
    step();
    #1 reset_ni = 0;
    #1;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_rreq", bus.rreq_o, 0);
    chk("mrst_raddr", bus.raddr_o, 0);
    chk("mrst_grant", grant_o, 1);
    chk("mrst_ack", m0_ack_o, 0);
    chk("mrst_tcnt", timeout_cnt_o, 0);
    chk("mrst_rdata", m0_rdata_o, 0);
    m0_req_i = 0;
    step();
    step();
    reset_ni = 1;
    m1_req_i = 1; m1_wr_i = 0; m1_addr_i = 9'h0AB;
    step();
    chk("post_rreq", bus.rreq_o, 1);
    chk("post_raddr", bus.raddr_o, 32'h0AB);
    step();
    bus.rack_i = 1; bus.rdata_i = 32'h11112222;
    step();
    bus.rack_i = 0;
    chk("post_ack", m1_ack_o, 1);
    chk("post_rdata", m1_rdata_o, 32'h11112222);
    chk("post_err", m1_err_o, 0);
    m1_req_i = 0;
    step();

    // both masters held from reset: m0 first, then strict alternation
    #1 reset_ni = 0;
    step();
    reset_ni = 1;
    m0_req_i = 1; m0_wr_i = 0; m1_req_i = 1; m1_wr_i = 0;
    bus.rack_i = 1; bus.rdata_i = 32'h0000CAFE;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("rr_ack0", m0_ack_o, (c % 8) == 3);
      chk("rr_ack1", m1_ack_o, (c % 8) == 7);
    end
    m0_req_i = 0; m1_req_i = 0; bus.rack_i = 0;
    step();
    step();

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      rand_cycle();
      if ($urandom_range(0, 299) == 0) begin
        #1 reset_ni = 0;
        m0_req_i = 0; m1_req_i = 0;
        step();
        step();
        reset_ni = 1;
      end
      step();
    end

    m0_req_i = 0; m1_req_i = 0; bus.rack_i = 0; bus.wack_i = 0;
    repeat (TMO + 4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
